// File: rtl/dut_div.sv
// Iterative restoring unsigned divider: one quotient bit per clock, MSB first,
// with valid/ready handshakes on the operand and result sides.
module dut_div #(
   parameter int BW_DATA = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BW_DATA-1:0] i_a,
   input  logic [BW_DATA-1:0] i_b,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW_DATA-1:0] o_q,
   output logic [BW_DATA-1:0] o_r,
   output logic               o_div0
);

   localparam int            CW        = $clog2(BW_DATA + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(BW_DATA - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // One restoring step: returns {quotient_bit, new_remainder}. The trial
   // difference borrows exactly when the shifted remainder is below the divisor,
   // because the remainder entering a step is always smaller than the divisor.
   function automatic logic [BW_DATA:0] f_restore(
      input logic [BW_DATA:0]   rem_s,
      input logic [BW_DATA-1:0] dvs
   );
      logic [BW_DATA:0] trial;
      logic             q_bit;
      trial = rem_s - {1'b0, dvs};
      q_bit = ~trial[BW_DATA];
      return q_bit ? {1'b1, trial[BW_DATA-1:0]} : {1'b0, rem_s[BW_DATA-1:0]};
   endfunction

   logic [1:0]         r_state;
   logic [BW_DATA-1:0] r_dvd;
   logic [BW_DATA-1:0] r_dvs;
   logic [BW_DATA-1:0] r_rem;
   logic [BW_DATA-1:0] r_quo;
   logic [CW-1:0]      r_cnt;
   logic               r_div0;

   logic [BW_DATA:0]   w_shift;
   logic [BW_DATA:0]   w_step;
   logic               w_qbit;
   logic [BW_DATA-1:0] w_rem_nx;

   assign w_shift  = {r_rem, r_dvd[BW_DATA-1]};
   assign w_step   = f_restore(w_shift, r_dvs);
   assign w_qbit   = w_step[BW_DATA];
   assign w_rem_nx = w_step[BW_DATA-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_div0  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  r_dvd   <= i_a;
                  r_dvs   <= i_b;
                  r_rem   <= '0;
                  r_quo   <= '0;
                  r_cnt   <= '0;
                  r_div0  <= (i_b == '0);
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               // A zero divisor spends a single cycle here, so its flagged
               // result appears one edge after acceptance.
               if (r_div0) begin
                  r_quo   <= '1;
                  r_rem   <= r_dvd;
                  r_state <= S_DONE;
               end else begin
                  r_rem <= w_rem_nx;
                  r_quo <= {r_quo[BW_DATA-2:0], w_qbit};
                  r_dvd <= {r_dvd[BW_DATA-2:0], 1'b0};
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == LAST_STEP) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (i_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_ready = (r_state == S_IDLE);
   assign o_valid = (r_state == S_DONE);
   assign o_q     = r_quo;
   assign o_r     = r_rem;
   assign o_div0  = r_div0;

endmodule
